out_port_bank: RTL and testbench

Parametrised output-port bank. It holds CHANNELS independent WIDTH-bit output latches and updates them through addressed bit writes, word writes and set/clear/toggle operations. An optional serial shift-out engine streams a snapshot of one channel to pins. It sits between the core's I/O write decode and the chip output pads, and generalises the single 8-bit bit-addressed output latch.

---
 rtl/outsel_pkg.sv | 35 +++
 rtl/outsel_shifter.sv | 109 ++++++++++
 rtl/out_port_bank.sv | 139 +++++++++++++
 tb/tb_out_port_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/outsel_pkg.sv
// outsel_pkg: definitions shared by the output-port bank and its serial shifter.
//   - OP_W      : width of the write operation field
//   - op_e      : write operation encoding (codes 5..7 are reserved)
//   - shift_state_e : shift-out engine state encoding
//   - op_is_valid / op_is_bit : write operation classification helpers
package outsel_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_BIT_WR  = 3'd0,
        OP_WORD_WR = 3'd1,
        OP_BIT_SET = 3'd2,
        OP_BIT_CLR = 3'd3,
        OP_BIT_TGL = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } shift_state_e;

    // Codes above OP_BIT_TGL are reserved and must be rejected.
    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return (op <= OP_BIT_TGL);
    endfunction

    // Every valid op except WORD_WR addresses a single bit.
    function automatic logic op_is_bit(input logic [OP_W-1:0] op);
        return (op != OP_WORD_WR);
    endfunction

endpackage

// File: rtl/outsel_shifter.sv
// outsel_shifter: serial shift-out engine for one output-latch channel.
// On shift_start with a valid channel it snapshots that channel's latch
// (during LOAD) and streams it MSB first, each bit held CLK_DIV clocks, with
// sclk high in the first clock of every bit, then pulses shift_done.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   shift_start     request a transfer (ignored while busy or chan invalid)
//   shift_chan      channel to transmit
//   latch           current latch contents of all channels
//   sdata, sclk     serial data / bit strobe
//   shift_busy      engine active (LOAD, SHIFT, DONE)
//   shift_done      one-cycle pulse in the final busy cycle
module outsel_shifter
    import outsel_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
    localparam int CNT_W   = $clog2(WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            shift_start,
    input  logic [CH_W-1:0]                 shift_chan,
    input  logic [CHANNELS-1:0][WIDTH-1:0]  latch,
    output logic                            sdata,
    output logic                            sclk,
    output logic                            shift_busy,
    output logic                            shift_done
);

    shift_state_e       state_reg, state_next;
    logic [CH_W-1:0]    chan_reg,  chan_next;
    logic [WIDTH-1:0]   sreg_reg,  sreg_next;
    logic [DIV_W-1:0]   div_reg,   div_next;
    logic [CNT_W-1:0]   bit_reg,   bit_next;
    logic               chan_ok;

    assign chan_ok = (32'(shift_chan) < 32'(CHANNELS));

    always_comb begin
        state_next = state_reg;
        chan_next  = chan_reg;
        sreg_next  = sreg_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        case (state_reg)
            S_IDLE: begin
                if (shift_start && chan_ok) begin
                    chan_next  = shift_chan;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // Registered latch value: a write landing on this same edge
                // is not part of the snapshot.
                sreg_next  = latch[chan_reg];
                div_next   = '0;
                bit_next   = '0;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_reg == DIV_W'(CLK_DIV - 1)) begin
                    div_next = '0;
                    if (bit_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        bit_next  = bit_reg + CNT_W'(1);
                        sreg_next = {sreg_reg[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            chan_reg  <= '0;
            sreg_reg  <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            chan_reg  <= chan_next;
            sreg_reg  <= sreg_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
        end
    end

    // Outputs decode registered state only, so they drop to 0 the cycle
    // after a reset.
    assign sdata      = (state_reg == S_SHIFT) & sreg_reg[WIDTH-1];
    assign sclk       = (state_reg == S_SHIFT) & (div_reg == '0);
    assign shift_busy = (state_reg != S_IDLE);
    assign shift_done = (state_reg == S_DONE);

endmodule

// File: rtl/out_port_bank.sv
// out_port_bank: CHANNELS independent WIDTH-bit output latches updated by
// addressed bit writes, word writes and bit set/clear/toggle operations,
// plus an optional serial shift-out engine.
// Build option: define OUTSEL_SHIFT_EN to build the shift engine; otherwise
// sdata/sclk/shift_busy/shift_done are tied to 0 and shift_start/shift_chan
// are unused.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ce, write           chip enable and write strobe
//   write_disable       global write inhibit (silent, no ack/err)
//   op                  operation (see outsel_pkg::op_e)
//   chan, bit_addr      target channel / bit
//   din_bit, din_word   data for BIT_WR / WORD_WR
//   out_latch           all latches, channel n at [n*WIDTH +: WIDTH]
//   write_ack/err       one-cycle pulse after an applied / rejected write
//   shift_start, shift_chan, sdata, sclk, shift_busy, shift_done: shift engine
module out_port_bank
    import outsel_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BIT_W   = $clog2(WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        write,
    input  logic                        write_disable,
    input  logic [OP_W-1:0]             op,
    input  logic [CH_W-1:0]             chan,
    input  logic [BIT_W-1:0]            bit_addr,
    input  logic                        din_bit,
    input  logic [WIDTH-1:0]            din_word,
    output logic [CHANNELS*WIDTH-1:0]   out_latch,
    output logic                        write_ack,
    output logic                        write_err,
    input  logic                        shift_start,
    input  logic [CH_W-1:0]             shift_chan,
    output logic                        sdata,
    output logic                        sclk,
    output logic                        shift_busy,
    output logic                        shift_done
);

    logic [CHANNELS-1:0][WIDTH-1:0] latch_q;
    logic                           wr_fire;
    logic                           wr_valid;
    logic                           chan_ok;
    logic                           bit_ok;
    logic [WIDTH-1:0]               bit_mask;
    logic                           write_ack_reg;
    logic                           write_err_reg;

    assign wr_fire  = ce & write & ~write_disable;
    assign chan_ok  = (32'(chan) < 32'(CHANNELS));
    assign bit_ok   = (32'(bit_addr) < 32'(WIDTH));
    // Word writes ignore bit_addr, so only bit ops need it in range.
    assign wr_valid = chan_ok & op_is_valid(op) & (~op_is_bit(op) | bit_ok);
    assign bit_mask = WIDTH'(1) << bit_addr;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] chan_reg;
            logic [WIDTH-1:0] chan_next;
            logic             hit;

            assign hit = wr_fire & wr_valid & (32'(chan) == 32'(gi));

            always_comb begin
                chan_next = chan_reg;
                if (hit) begin
                    case (op_e'(op))
                        OP_BIT_WR:  chan_next = din_bit ? (chan_reg | bit_mask)
                                                        : (chan_reg & ~bit_mask);
                        OP_WORD_WR: chan_next = din_word;
                        OP_BIT_SET: chan_next = chan_reg | bit_mask;
                        OP_BIT_CLR: chan_next = chan_reg & ~bit_mask;
                        OP_BIT_TGL: chan_next = chan_reg ^ bit_mask;
                        default:    chan_next = chan_reg;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    chan_reg <= '0;
                end else begin
                    chan_reg <= chan_next;
                end
            end

            assign latch_q[gi] = chan_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            write_ack_reg <= 1'b0;
            write_err_reg <= 1'b0;
        end else begin
            write_ack_reg <= wr_fire & wr_valid;
            write_err_reg <= wr_fire & ~wr_valid;
        end
    end

    assign out_latch = latch_q;
    assign write_ack = write_ack_reg;
    assign write_err = write_err_reg;

`ifdef OUTSEL_SHIFT_EN
    outsel_shifter #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .CLK_DIV  (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .shift_start (shift_start),
        .shift_chan  (shift_chan),
        .latch       (latch_q),
        .sdata       (sdata),
        .sclk        (sclk),
        .shift_busy  (shift_busy),
        .shift_done  (shift_done)
    );
`else
    localparam int unused_clk_div = CLK_DIV;
    logic unused_shift_in;
    assign unused_shift_in = ^{shift_start, shift_chan};
    assign sdata      = 1'b0;
    assign sclk       = 1'b0;
    assign shift_busy = 1'b0;
    assign shift_done = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_bank.sv
// tb_out_port_bank: self-checking bench for out_port_bank.
// Instance A uses CHANNELS=4, WIDTH=8, CLK_DIV=2; instance B uses
// CHANNELS=3, WIDTH=6 so that out-of-range channel and bit addresses are
// reachable. Both see the same write stimulus and are compared every cycle
// against a per-channel integer model. Shift tests run when OUTSEL_SHIFT_EN
// is defined; otherwise the shift outputs are checked to stay 0.
module tb_out_port_bank;
    import outsel_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce, write, write_disable, din_bit, shift_start;
    logic [2:0]  op;
    logic [1:0]  chan, shift_chan;
    logic [2:0]  bit_addr;
    logic [7:0]  din_word;

    logic [31:0] out_a;
    logic        ack_a, err_a, sdata_a, sclk_a, busy_a, done_a;
    logic [17:0] out_b;
    logic        ack_b, err_b, sdata_b, sclk_b, busy_b, done_b;

    always #5 clk = ~clk;

    out_port_bank #(.CHANNELS(4), .WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .write(write), .write_disable(write_disable),
        .op(op), .chan(chan), .bit_addr(bit_addr), .din_bit(din_bit), .din_word(din_word),
        .out_latch(out_a), .write_ack(ack_a), .write_err(err_a),
        .shift_start(shift_start), .shift_chan(shift_chan),
        .sdata(sdata_a), .sclk(sclk_a), .shift_busy(busy_a), .shift_done(done_a)
    );

    out_port_bank #(.CHANNELS(3), .WIDTH(6), .CLK_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .write(write), .write_disable(write_disable),
        .op(op), .chan(chan), .bit_addr(bit_addr), .din_bit(din_bit), .din_word(din_word[5:0]),
        .out_latch(out_b), .write_ack(ack_b), .write_err(err_b),
        .shift_start(1'b0), .shift_chan(2'd0),
        .sdata(sdata_b), .sclk(sclk_b), .shift_busy(busy_b), .shift_done(done_b)
    );

    // Reference model: one integer per channel, per instance.
    int   nch [2] = '{4, 3};
    int   wid [2] = '{8, 6};
    int   model [2][4];
    logic exp_ack [2];
    logic exp_err [2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flat(input int d);
        logic [31:0] r = '0;
        for (int n = 0; n < nch[d]; n++)
            r |= 32'(model[d][n]) << (n * wid[d]);
        return r;
    endfunction

    // One clock: advance the model with the inputs sampled at this edge and
    // compare both instances' write-side outputs.
    task automatic cycle();
        int c, b, m;
        bit valid;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_ack[d] = 1'b0;
            exp_err[d] = 1'b0;
            if (rst) begin
                for (int n = 0; n < 4; n++) model[d][n] = 0;
            end else if (ce && write && !write_disable) begin
                c = int'(chan);
                b = int'(bit_addr);
                valid = (c < nch[d]) && (op <= 3'd4) && (op == 3'd1 || b < wid[d]);
                if (!valid) begin
                    exp_err[d] = 1'b1;
                end else begin
                    exp_ack[d] = 1'b1;
                    m = 1 << b;
                    case (op)
                        3'd0: model[d][c] = din_bit ? (model[d][c] | m) : (model[d][c] & ~m);
                        3'd1: model[d][c] = int'(din_word) & ((1 << wid[d]) - 1);
                        3'd2: model[d][c] = model[d][c] | m;
                        3'd3: model[d][c] = model[d][c] & ~m;
                        default: model[d][c] = model[d][c] ^ m;
                    endcase
                end
            end
        end
        check_eq("latch_a", out_a, flat(0));
        check_eq("ack_a", ack_a, exp_ack[0]);
        check_eq("err_a", err_a, exp_err[0]);
        check_eq("latch_b", {14'd0, out_b}, flat(1));
        check_eq("ack_b", ack_b, exp_ack[1]);
        check_eq("err_b", err_b, exp_err[1]);
        check_eq("shift_b_idle", {sdata_b, sclk_b, busy_b, done_b}, 4'd0);
    endtask

    task automatic set_wr(input logic [2:0] o, input int c, input int b,
                          input logic db, input logic [7:0] w);
        write = 1'b1; op = o; chan = 2'(c); bit_addr = 3'(b); din_bit = db; din_word = w;
    endtask

    task automatic idle();
        write = 1'b0; ce = 1'b1; write_disable = 1'b0;
    endtask

    task automatic chk_shift_zero(input string tag);
        check_eq(tag, {sdata_a, sclk_a, busy_a, done_a}, 4'd0);
    endtask

`ifdef OUTSEL_SHIFT_EN
    // Start a transfer and follow it edge by edge. wr_k: edge at which a
    // WORD_WR 0x00 to the same channel is sampled; rst_k: edge at which
    // reset is sampled (-1 for none). A second shift_start at edge 4 must be
    // ignored.
    task automatic run_shift(input int ch, input logic [7:0] exp_b,
                             input int wr_k, input int rst_k);
        logic e_sd, e_sc, e_bz, e_dn;
        int bi;
        shift_start = 1'b1; shift_chan = 2'(ch);
        cycle();
        shift_start = 1'b0;
        check_eq("load_busy", busy_a, 1'b1);
        check_eq("load_sig", {sdata_a, sclk_a, done_a}, 3'd0);
        for (int k = 1; k <= 19; k++) begin
            if (k == wr_k) set_wr(3'd1, ch, 0, 1'b0, 8'h00);
            if (k == 4) begin shift_start = 1'b1; shift_chan = 2'(ch ^ 1); end
            if (k == rst_k) rst = 1'b1;
            cycle();
            write = 1'b0; shift_start = 1'b0;
            if (k == rst_k) begin
                rst = 1'b0;
                chk_shift_zero("rst_shift_out");
                check_eq("rst_latch", out_a, 32'd0);
                for (int j = 0; j < 4; j++) begin
                    cycle();
                    chk_shift_zero("post_rst_quiet");
                end
                return;
            end
            e_bz = (k <= 17);
            e_dn = (k == 17);
            if (k <= 16) begin
                bi   = (k - 1) / 2;
                e_sd = exp_b[7 - bi];
                e_sc = ((k - 1) % 2 == 0);
            end else begin
                e_sd = 1'b0;
                e_sc = 1'b0;
            end
            check_eq($sformatf("busy_k%0d", k), busy_a, e_bz);
            check_eq($sformatf("done_k%0d", k), done_a, e_dn);
            check_eq($sformatf("sdata_k%0d", k), sdata_a, e_sd);
            check_eq($sformatf("sclk_k%0d", k), sclk_a, e_sc);
        end
    endtask
`endif

    initial begin
        ce = 1'b1; write = 1'b0; write_disable = 1'b0; op = '0; chan = '0;
        bit_addr = '0; din_bit = 1'b0; din_word = '0; shift_start = 1'b0; shift_chan = '0;
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 4; n++) model[d][n] = 0;

        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("reset_latch", out_a, 32'd0);
        chk_shift_zero("reset_shift");

        // Directed sequence on channel 2.
        set_wr(3'd1, 2, 0, 1'b0, 8'hA5); cycle();
        check_eq("word_a5", out_a, 32'h00A5_0000);
        check_eq("word_ack", ack_a, 1'b1);
        idle(); cycle();
        check_eq("ack_one_cycle", ack_a, 1'b0);
        set_wr(3'd2, 2, 1, 1'b0, 8'h00); cycle();
        check_eq("set_bit1", out_a[23:16], 8'hA7);
        set_wr(3'd3, 2, 7, 1'b0, 8'h00); cycle();
        check_eq("clr_bit7", out_a[23:16], 8'h27);
        set_wr(3'd4, 2, 0, 1'b0, 8'h00); cycle();
        check_eq("tgl_bit0", out_a[23:16], 8'h26);
        set_wr(3'd0, 2, 3, 1'b1, 8'h00); write_disable = 1'b1; cycle();
        check_eq("wdis_nochange", out_a[23:16], 8'h26);
        check_eq("wdis_noack", {ack_a, err_a}, 2'b00);
        write_disable = 1'b0; ce = 1'b0; cycle();
        check_eq("ce_off_noack", {ack_a, err_a}, 2'b00);
        ce = 1'b1;
        set_wr(3'd6, 2, 0, 1'b1, 8'hFF); cycle();
        check_eq("op6_err", err_a, 1'b1);
        check_eq("op6_nochange", out_a[23:16], 8'h26);
        set_wr(3'd1, 3, 0, 1'b0, 8'h3C); cycle();
        check_eq("b_chan3_err", err_b, 1'b1);
        check_eq("a_chan3_ok", out_a[31:24], 8'h3C);
        set_wr(3'd2, 0, 6, 1'b0, 8'h00); cycle();
        check_eq("b_bit6_err", err_b, 1'b1);
        check_eq("a_bit6_set", out_a[7:0], 8'h40);
        idle(); cycle();

        // Randomized back-to-back traffic.
        for (int i = 0; i < 250; i++) begin
            ce            = ($urandom_range(0, 9) != 0);
            write         = ($urandom_range(0, 5) != 0);
            write_disable = ($urandom_range(0, 9) == 0);
            op            = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                                        : 3'($urandom_range(0, 4));
            chan          = 2'($urandom_range(0, 3));
            bit_addr      = 3'($urandom_range(0, 7));
            din_bit       = 1'($urandom);
            din_word      = 8'($urandom);
            cycle();
        end
        idle(); cycle();

`ifdef OUTSEL_SHIFT_EN
        set_wr(3'd1, 1, 0, 1'b0, 8'h81); cycle(); idle();
        run_shift(1, 8'h81, -1, -1);
        set_wr(3'd1, 1, 0, 1'b0, 8'h81); cycle(); idle();
        run_shift(1, 8'h81, 4, -1);
        check_eq("wr_during_shift", out_a[15:8], 8'h00);
        set_wr(3'd1, 3, 0, 1'b0, 8'h5C); cycle(); idle();
        run_shift(3, 8'h5C, -1, 6);
        set_wr(3'd1, 3, 0, 1'b0, 8'hC3); cycle(); idle();
        run_shift(3, 8'hC3, -1, -1);
`else
        shift_start = 1'b1; shift_chan = 2'd1;
        cycle();
        chk_shift_zero("noshift_1");
        cycle();
        shift_start = 1'b0;
        chk_shift_zero("noshift_2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
